// File: rtl/agriculture_soc_pkg.sv
// agriculture_soc_pkg: shared FSM states, LFSR mask, LED bit positions and filter depth
package agriculture_soc_pkg;
    typedef enum logic [1:0] {IDLE, SAMPLE, FILTER, DECIDE} state_e;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int LED_HB = 0;
    localparam int LED_PUMP = 1;
    localparam int LED_DRY = 2;
    localparam int LED_FAULT = 3;
    localparam int FILT_DEPTH = 4;
endpackage

// File: rtl/agri_lfsr_sensor.sv
// agri_lfsr_sensor: Galois LFSR soil-moisture model with advance enable and invalid-sample flag
module agri_lfsr_sensor
    import agriculture_soc_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adv_i,
    output logic [7:0] sample_o,
    output logic       invalid_o
);
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = lfsr_q[0] ? (lfsr_q >> 1) ^ LFSR_MASK : lfsr_q >> 1;
    assign sample_o = lfsr_q[7:0];
    assign invalid_o = (sample_o == 8'h00) || (sample_o == 8'hFF);
    // Shift register advances only when the controller accepts a tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= SEED;
        else if (adv_i) lfsr_q <= lfsr_d;
    end
endmodule

// File: rtl/agriculture_soc.sv
// agriculture_soc: tick-driven soil sensor, 4-sample averaging, pump/dry/fault/heartbeat LEDs; AGRI_SOC_HYSTERESIS_EN enables two-threshold pump control
module agriculture_soc
    import agriculture_soc_pkg::*;
#(
    parameter int          TICK_DIV  = 100,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [7:0]  DRY_TH    = 8'd96,
    parameter logic [7:0]  WET_TH    = 8'd160,
    parameter int          HB_TICKS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] LED
);
`ifdef AGRI_SOC_HYSTERESIS_EN
    localparam bit HYST_EN = 1'b1;
`else
    localparam bit HYST_EN = 1'b0;
`endif
    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HB_TICKS + 1);
    logic [PW-1:0] pre_q;
    logic [HW-1:0] hb_q;
    logic          hb_led_q, pump_q, dry_q, fault_q, fault_led_q;
    state_e        state_q;
    logic [7:0]    win_q [FILT_DEPTH];
    logic [9:0]    sum_q, sum_d;
    logic [2:0]    vcnt_q;
    logic [7:0]    sample, avg;
    logic          invalid, tick, hb_wrap, adv, avg_ok, pump_d;
    assign tick = pre_q == PW'(TICK_DIV - 1);
    assign hb_wrap = hb_q == HW'(HB_TICKS - 1);
    assign adv = tick && (state_q == IDLE);
    assign avg = 8'(sum_q >> 2);
    assign avg_ok = vcnt_q == 3'(FILT_DEPTH);
    // Pump turns on below DRY_TH and, with hysteresis, stays on until the average reaches WET_TH
    assign pump_d = (avg < DRY_TH) || (HYST_EN && pump_q && (avg < WET_TH));
    assign LED[LED_HB] = hb_led_q;
    assign LED[LED_PUMP] = pump_q;
    assign LED[LED_DRY] = dry_q;
    assign LED[LED_FAULT] = fault_led_q;
    agri_lfsr_sensor #(.SEED(LFSR_SEED)) u_sensor (
        .clk      (clk),
        .reset    (reset),
        .adv_i    (adv),
        .sample_o (sample),
        .invalid_o(invalid)
    );
    // Window sum, registered during FILTER
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < FILT_DEPTH; i++) sum_d = sum_d + 10'(win_q[i]);
    end
    // Free-running prescaler and heartbeat, independent of the FSM so the tick cadence never slips
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            hb_q <= '0;
            hb_led_q <= 1'b0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                hb_q <= hb_wrap ? '0 : hb_q + 1'b1;
                hb_led_q <= hb_led_q ^ hb_wrap;
            end
        end
    end
    // Sample pipeline: IDLE waits for a tick, SAMPLE screens and shifts, FILTER sums, DECIDE drives LEDs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < FILT_DEPTH; i++) win_q[i] <= '0;
            sum_q <= '0;
            vcnt_q <= '0;
            fault_q <= 1'b0;
            fault_led_q <= 1'b0;
            pump_q <= 1'b0;
            dry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (tick) state_q <= SAMPLE;
                SAMPLE: begin
                    fault_q <= invalid;
                    if (!invalid) begin
                        win_q[0] <= sample;
                        for (int i = 1; i < FILT_DEPTH; i++) win_q[i] <= win_q[i-1];
                        if (!avg_ok) vcnt_q <= vcnt_q + 1'b1;
                    end
                    state_q <= FILTER;
                end
                FILTER: begin
                    sum_q <= sum_d;
                    state_q <= DECIDE;
                end
                default: begin
                    pump_q <= avg_ok && pump_d;
                    dry_q <= avg_ok && (avg < (DRY_TH >> 1));
                    fault_led_q <= fault_q;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_agriculture_soc.sv
// tb_agriculture_soc: directed checks of sampling, filtering, pump/dry/fault/heartbeat LEDs and reset
module tb_agriculture_soc;
    import agriculture_soc_pkg::*;
`ifdef AGRI_SOC_HYSTERESIS_EN
    localparam bit HYST = 1'b1;
`else
    localparam bit HYST = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] led_a, led_b, led_c, led_d, led_f;
    int nvec = 0;
    int nerr = 0;
    logic [7:0] smp [16] = '{8'h70, 8'h38, 8'h9C, 8'h4E, 8'h27, 8'h13, 8'h89, 8'hC4,
                            8'h62, 8'hB1, 8'h58, 8'h2C, 8'h16, 8'h8B, 8'hC5, 8'h62};
    int avg_t [16] = '{0, 0, 0, 100, 82, 73, 68, 97, 112, 152, 139, 101, 82, 73, 100, 114};
    always #5 clk = ~clk;
    agriculture_soc #(.TICK_DIV(4), .DRY_TH(8'd120), .WET_TH(8'd200), .HB_TICKS(8)) u_a (
        .clk(clk), .reset(reset), .LED(led_a));
    agriculture_soc #(.TICK_DIV(4), .DRY_TH(8'd96), .WET_TH(8'd160), .HB_TICKS(8)) u_b (
        .clk(clk), .reset(reset), .LED(led_b));
    agriculture_soc #(.TICK_DIV(4), .DRY_TH(8'd200), .WET_TH(8'd240), .HB_TICKS(8)) u_c (
        .clk(clk), .reset(reset), .LED(led_c));
    agriculture_soc #(.TICK_DIV(2), .HB_TICKS(8)) u_d (
        .clk(clk), .reset(reset), .LED(led_d));
    agriculture_soc #(.TICK_DIV(4), .LFSR_SEED(16'h69FF), .HB_TICKS(8)) u_f (
        .clk(clk), .reset(reset), .LED(led_f));
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask
    function automatic logic pump_next(input int a, input int dry, input int wet, input logic p);
        if (a < dry) return 1'b1;
        if (!HYST || a >= wet) return 1'b0;
        return p;
    endfunction
    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        logic [2:0] ea, eb, ec;
        logic pa, pb, pc, hb;
        int k, a;
        ea = '0; eb = '0; ec = '0;
        pa = 1'b0; pb = 1'b0; pc = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_led_a", 16'(led_a), 16'h0);
        chk("rst_state", 16'(u_a.state_q), 16'(IDLE));
        for (int e = 1; e <= 68; e++) begin
            step(1);
            if (e % 4 == 3 && e >= 7) begin
                k = (e - 3) / 4;
                if (k >= 4) begin
                    a = avg_t[k-1];
                    pa = pump_next(a, 120, 200, pa);
                    pb = pump_next(a, 96, 160, pb);
                    pc = pump_next(a, 200, 240, pc);
                    ea = {1'b0, a < 60, pa};
                    eb = {1'b0, a < 48, pb};
                    ec = {1'b0, a < 100, pc};
                end
            end
            hb = 1'((e / 32) % 2);
            chk("led_a", 16'(led_a), 16'({ea, hb}));
            chk("led_b", 16'(led_b), 16'({eb, hb}));
            chk("led_c", 16'(led_c), 16'({ec, hb}));
            if (e % 4 == 0 && e <= 64) chk("sample_b", 16'(u_b.sample), 16'(smp[e/4-1]));
            if (e == 4) chk("state_sample", 16'(u_a.state_q), 16'(SAMPLE));
            if (e == 5) chk("state_filter", 16'(u_a.state_q), 16'(FILTER));
            if (e == 18) chk("sum4_b", 16'(u_b.sum_q), 16'd402);
            if (e == 2 || e == 4) chk("drop_d", 16'(u_d.sample), 16'h70);
            if (e == 6) chk("adv2_d", 16'(u_d.sample), 16'h38);
            if (e == 10) chk("adv3_d", 16'(u_d.sample), 16'h9C);
            if (e == 4) chk("ff_sample", 16'(u_f.sample), 16'hFF);
            if (e == 6) chk("fault_pre", 16'(led_f), 16'h0);
            if (e == 7) begin
                chk("fault_set", 16'(led_f), 16'b1000);
                chk("fault_vcnt", 16'(u_f.vcnt_q), 16'd0);
                chk("fault_win", 16'(u_f.win_q[0]), 16'h0);
            end
            if (e == 11) begin
                chk("fault_clr", 16'(led_f), 16'h0);
                chk("fault_vcnt1", 16'(u_f.vcnt_q), 16'd1);
                chk("fault_win1", 16'(u_f.win_q[0]), 16'h7F);
            end
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_led_a", 16'(led_a), 16'h0);
        chk("arst_led_c", 16'(led_c), 16'h0);
        chk("arst_state", 16'(u_a.state_q), 16'(IDLE));
        chk("arst_lfsr", u_a.u_sensor.lfsr_q, 16'hACE1);
        chk("arst_vcnt", 16'(u_b.vcnt_q), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        step(3);
        chk("post_led_a", 16'(led_a), 16'h0);
        step(1);
        chk("post_sample", 16'(u_b.sample), 16'h70);
        chk("post_state", 16'(u_a.state_q), 16'(SAMPLE));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
